// File: rtl/game_message_typewriter.sv
// Message typewriter: clears the character buffer, then writes the selected message one letter
// at a time, paced by start-of-frame pulses. All outputs come straight from registers.
module game_message_typewriter #(
  parameter int unsigned MaxLen         = 16,
  parameter int unsigned LetterW        = 6,
  parameter int unsigned TicksPerLetter = 4
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic                      start_i,
  input  logic [1:0]                msg_id_i,
  input  logic                      start_of_frame_i,
  input  logic                      wr_ready_i,
  output logic                      wr_en_o,
  output logic [$clog2(MaxLen)-1:0] wr_addr_o,
  output logic [LetterW-1:0]        wr_letter_o,
  output logic                      busy_o,
  output logic                      done_o
);

  localparam int unsigned AddrW = $clog2(MaxLen);
  localparam int unsigned LenW  = $clog2(MaxLen + 1);
  localparam int unsigned TickW = $clog2(TicksPerLetter + 1);

  typedef enum logic [2:0] {StIdle, StClear, StWaitTick, StWrite, StDone} state_e;

  state_e             state_q;
  logic [1:0]         msg_q;
  logic [AddrW-1:0]   clr_cnt_q;
  logic [AddrW-1:0]   idx_q;
  logic [TickW-1:0]   tick_cnt_q;
  logic               wr_en_q;
  logic [AddrW-1:0]   wr_addr_q;
  logic [LetterW-1:0] wr_letter_q;
  logic               busy_q;
  logic               done_q;

  logic [LenW-1:0]    rom_len;
  logic [LetterW-1:0] rom_letter;
  logic               last_letter;

  function automatic logic [LenW-1:0] rom_len_f(input logic [1:0] msg);
    unique case (msg)
      2'd0:    return LenW'(6);
      2'd1:    return LenW'(4);
      2'd2:    return LenW'(3);
      default: return '0;
    endcase
  endfunction

  function automatic logic [LetterW-1:0] rom_letter_f(input logic [1:0] msg, input int i);
    unique case (msg)
      2'd0: begin
        case (i)
          0:       return LetterW'(14);
          1:       return LetterW'(2);
          2:       return LetterW'(12);
          3:       return LetterW'(6);
          4:       return LetterW'(15);
          5:       return LetterW'(4);
          default: return '0;
        endcase
      end
      2'd1: begin
        case (i)
          0:       return LetterW'(7);
          1:       return LetterW'(1);
          2:       return LetterW'(13);
          3:       return LetterW'(5);
          default: return '0;
        endcase
      end
      2'd2: begin
        case (i)
          0:       return LetterW'(19);
          1:       return LetterW'(8);
          2:       return LetterW'(11);
          default: return '0;
        endcase
      end
      default: return '0;
    endcase
  endfunction

  always_comb begin
    rom_len     = rom_len_f(msg_q);
    rom_letter  = rom_letter_f(msg_q, int'(idx_q));
    last_letter = (LenW'(idx_q) + LenW'(1)) == rom_len;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= StIdle;
      msg_q       <= '0;
      clr_cnt_q   <= '0;
      idx_q       <= '0;
      tick_cnt_q  <= '0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_letter_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            msg_q       <= msg_id_i;
            clr_cnt_q   <= '0;
            state_q     <= StClear;
            busy_q      <= 1'b1;
            wr_en_q     <= 1'b1;
            wr_addr_q   <= '0;
            wr_letter_q <= '0;
          end
        end
        StClear: begin
          if (wr_ready_i) begin
            if (clr_cnt_q == AddrW'(MaxLen - 1)) begin
              wr_en_q <= 1'b0;
              if (rom_len == '0) begin
                state_q <= StDone;
                done_q  <= 1'b1;
                busy_q  <= 1'b0;
              end else begin
                idx_q      <= '0;
                tick_cnt_q <= '0;
                state_q    <= StWaitTick;
              end
            end else begin
              clr_cnt_q <= clr_cnt_q + AddrW'(1);
              wr_addr_q <= clr_cnt_q + AddrW'(1);
            end
          end
        end
        StWaitTick: begin
          // Frame pulses only count here; CLEAR and WRITE ignore them.
          if (start_of_frame_i) begin
            if (tick_cnt_q == TickW'(TicksPerLetter - 1)) begin
              tick_cnt_q  <= '0;
              state_q     <= StWrite;
              wr_en_q     <= 1'b1;
              wr_addr_q   <= idx_q;
              wr_letter_q <= rom_letter;
            end else begin
              tick_cnt_q <= tick_cnt_q + TickW'(1);
            end
          end
        end
        StWrite: begin
          if (wr_ready_i) begin
            wr_en_q <= 1'b0;
            if (last_letter) begin
              state_q <= StDone;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
            end else begin
              idx_q   <= idx_q + AddrW'(1);
              state_q <= StWaitTick;
            end
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign wr_en_o     = wr_en_q;
  assign wr_addr_o   = wr_addr_q;
  assign wr_letter_o = wr_letter_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;

endmodule
